// File: rtl/route_compute_unit_pkg.sv
// Shared definitions for the router route-computation stage.
// Contents:
//   - FLIT_TYPE_*    : 2-bit flit type encodings
//   - ROUTING_MODE_* : dimension-order routing mode encodings
//   - DIRECTION_*    : port-direction indices (bit positions in one-hot port vectors)
//   - opposite_direction() : maps a direction to the one facing it
package route_compute_unit_pkg;

   typedef logic [1:0] flit_type_t;

   localparam flit_type_t FLIT_TYPE_BODY     = 2'b00;
   localparam flit_type_t FLIT_TYPE_HEAD     = 2'b01;
   localparam flit_type_t FLIT_TYPE_TAIL     = 2'b10;
   localparam flit_type_t FLIT_TYPE_HEADTAIL = 2'b11;

   localparam logic ROUTING_MODE_XY = 1'b0;
   localparam logic ROUTING_MODE_YX = 1'b1;

   localparam int unsigned DIRECTION_LOCAL = 0;
   localparam int unsigned DIRECTION_NORTH = 1;
   localparam int unsigned DIRECTION_EAST  = 2;
   localparam int unsigned DIRECTION_SOUTH = 3;
   localparam int unsigned DIRECTION_WEST  = 4;
   localparam int unsigned NUM_DIRECTIONS  = 5;

   function automatic int unsigned opposite_direction(int unsigned dir);
      int unsigned result;
      case (dir)
         DIRECTION_NORTH: result = DIRECTION_SOUTH;
         DIRECTION_SOUTH: result = DIRECTION_NORTH;
         DIRECTION_EAST:  result = DIRECTION_WEST;
         DIRECTION_WEST:  result = DIRECTION_EAST;
         default:         result = DIRECTION_LOCAL;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/route_compute_unit_route_select_dor.sv
// route_select_dor: combinational dimension-order route selection.
// Ports:
//   x_cur_i, y_cur_i   : this node's coordinates
//   x_dst_i, y_dst_i   : destination coordinates from the head flit
//   routing_mode_i     : ROUTING_MODE_XY resolves X first, ROUTING_MODE_YX resolves Y first
//   port_onehot_o      : exactly one bit set, indexed by DIRECTION_* constants
module route_select_dor
   import route_compute_unit_pkg::*;
#(
   parameter int unsigned DimensionXWidth     = 2,
   parameter int unsigned DimensionYWidth     = 2,
   parameter int unsigned NumberOfPorts       = 5,
   parameter int unsigned NodeIdIncreaseXAxis = DIRECTION_EAST,
   parameter int unsigned NodeIdIncreaseYAxis = DIRECTION_SOUTH
) (
   input  logic [DimensionXWidth-1:0] x_cur_i,
   input  logic [DimensionYWidth-1:0] y_cur_i,
   input  logic [DimensionXWidth-1:0] x_dst_i,
   input  logic [DimensionYWidth-1:0] y_dst_i,
   input  logic                       routing_mode_i,
   output logic [NumberOfPorts-1:0]   port_onehot_o
);

   localparam logic [NumberOfPorts-1:0] OneHotBase = NumberOfPorts'(1);
   localparam logic [NumberOfPorts-1:0] LocalMask  = OneHotBase << DIRECTION_LOCAL;
   localparam logic [NumberOfPorts-1:0] XIncMask   = OneHotBase << NodeIdIncreaseXAxis;
   localparam logic [NumberOfPorts-1:0] XDecMask   =
      OneHotBase << opposite_direction(NodeIdIncreaseXAxis);
   localparam logic [NumberOfPorts-1:0] YIncMask   = OneHotBase << NodeIdIncreaseYAxis;
   localparam logic [NumberOfPorts-1:0] YDecMask   =
      OneHotBase << opposite_direction(NodeIdIncreaseYAxis);

   logic                     x_differs;
   logic                     y_differs;
   logic [NumberOfPorts-1:0] x_mask;
   logic [NumberOfPorts-1:0] y_mask;

   always_comb begin
      x_differs = (x_dst_i != x_cur_i);
      y_differs = (y_dst_i != y_cur_i);
      // Direction along each axis: towards increasing ids if the destination is larger
      x_mask    = (x_dst_i > x_cur_i) ? XIncMask : XDecMask;
      y_mask    = (y_dst_i > y_cur_i) ? YIncMask : YDecMask;

      port_onehot_o = LocalMask;
      if (routing_mode_i == ROUTING_MODE_XY) begin
         if (x_differs) begin
            port_onehot_o = x_mask;
         end else if (y_differs) begin
            port_onehot_o = y_mask;
         end
      end else begin
         if (y_differs) begin
            port_onehot_o = y_mask;
         end else if (x_differs) begin
            port_onehot_o = x_mask;
         end
      end
   end

endmodule

// File: rtl/route_compute_unit.sv
// route_compute_unit: per-input-port, VC-aware route computation stage.
// Head flits get a dimension-order route from their destination field; the route is held
// per VC until the tail. Every forwarded flit passes one registered valid/ready stage.
// Ports:
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   x_cur_i, y_cur_i             : this node's coordinates (quasi-static)
//   flit_i, flit_type_i, vc_id_i : incoming flit, its type and VC
//   routing_mode_i               : XY/YX, sampled on accepted HEAD/HEADTAIL
//   valid_i / ready_o            : input handshake
//   flit_o, flit_type_o, vc_id_o : registered outgoing flit
//   port_onehot_o                : route of flit_o
//   valid_o / ready_i            : output handshake
//   error_o                      : sticky protocol-error flag
module route_compute_unit
   import route_compute_unit_pkg::*;
#(
   parameter int unsigned FlitWidth               = 64,
   parameter int unsigned DimensionXWidth         = 2,
   parameter int unsigned DimensionYWidth         = 2,
   parameter int unsigned DstXLsb                 = 0,
   parameter int unsigned DstYLsb                 = 2,
   parameter int unsigned NumberOfVirtualChannels = 4,
   parameter int unsigned NumberOfPorts           = 5,
   parameter int unsigned NodeIdIncreaseXAxis     = DIRECTION_EAST,
   parameter int unsigned NodeIdIncreaseYAxis     = DIRECTION_SOUTH,
   localparam int unsigned VcIdWidth =
      (NumberOfVirtualChannels > 1) ? $clog2(NumberOfVirtualChannels) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [DimensionXWidth-1:0] x_cur_i,
   input  logic [DimensionYWidth-1:0] y_cur_i,
   input  logic [FlitWidth-1:0]       flit_i,
   input  logic [1:0]                 flit_type_i,
   input  logic [VcIdWidth-1:0]       vc_id_i,
   input  logic                       routing_mode_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [FlitWidth-1:0]       flit_o,
   output logic [1:0]                 flit_type_o,
   output logic [VcIdWidth-1:0]       vc_id_o,
   output logic [NumberOfPorts-1:0]   port_onehot_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic                       error_o
);

   typedef logic [NumberOfVirtualChannels-1:0][NumberOfPorts-1:0] route_table_t;

   logic [FlitWidth-1:0]               flit_q, flit_d;
   logic [1:0]                         flit_type_q, flit_type_d;
   logic [VcIdWidth-1:0]               vc_id_q, vc_id_d;
   logic [NumberOfPorts-1:0]           port_q, port_d;
   logic                               valid_q, valid_d;
   logic                               error_q, error_d;
   logic [NumberOfVirtualChannels-1:0] active_q, active_d;
   route_table_t                       route_q, route_d;

   logic                               accept;
   logic                               is_head;
   logic                               vc_active;
   logic                               drop;
   logic [NumberOfPorts-1:0]           head_route;
   logic [NumberOfPorts-1:0]           fwd_route;

   route_select_dor #(
      .DimensionXWidth     (DimensionXWidth),
      .DimensionYWidth     (DimensionYWidth),
      .NumberOfPorts       (NumberOfPorts),
      .NodeIdIncreaseXAxis (NodeIdIncreaseXAxis),
      .NodeIdIncreaseYAxis (NodeIdIncreaseYAxis)
   ) u_route_select_dor (
      .x_cur_i        (x_cur_i),
      .y_cur_i        (y_cur_i),
      .x_dst_i        (flit_i[DstXLsb +: DimensionXWidth]),
      .y_dst_i        (flit_i[DstYLsb +: DimensionYWidth]),
      .routing_mode_i (routing_mode_i),
      .port_onehot_o  (head_route)
   );

   // Output register is free when empty or being drained this cycle
   assign ready_o = ~valid_q | ready_i;
   assign accept  = valid_i & ready_o;

   always_comb begin
      is_head   = (flit_type_i == FLIT_TYPE_HEAD) || (flit_type_i == FLIT_TYPE_HEADTAIL);
      vc_active = active_q[vc_id_i];
      // BODY/TAIL with no open packet on its VC is consumed but never forwarded
      drop      = accept & ~is_head & ~vc_active;
      fwd_route = is_head ? head_route : route_q[vc_id_i];
   end

   always_comb begin
      flit_d      = flit_q;
      flit_type_d = flit_type_q;
      vc_id_d     = vc_id_q;
      port_d      = port_q;
      valid_d     = valid_q;
      error_d     = error_q;
      active_d    = active_q;
      route_d     = route_q;

      if (accept) begin
         valid_d = ~drop;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end

      if (accept && !drop) begin
         flit_d      = flit_i;
         flit_type_d = flit_type_i;
         vc_id_d     = vc_id_i;
         port_d      = fwd_route;
      end

      if (accept && flit_type_i == FLIT_TYPE_HEAD) begin
         // A HEAD on an open VC still wins: route is replaced, error is flagged
         route_d[vc_id_i]  = head_route;
         active_d[vc_id_i] = 1'b1;
         if (vc_active) begin
            error_d = 1'b1;
         end
      end

      if (accept && flit_type_i == FLIT_TYPE_TAIL && vc_active) begin
         active_d[vc_id_i] = 1'b0;
      end

      if (drop) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flit_q      <= '0;
         flit_type_q <= '0;
         vc_id_q     <= '0;
         port_q      <= '0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
         active_q    <= '0;
         route_q     <= '0;
      end else begin
         flit_q      <= flit_d;
         flit_type_q <= flit_type_d;
         vc_id_q     <= vc_id_d;
         port_q      <= port_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
         active_q    <= active_d;
         route_q     <= route_d;
      end
   end

   assign flit_o        = flit_q;
   assign flit_type_o   = flit_type_q;
   assign vc_id_o       = vc_id_q;
   assign port_onehot_o = port_q;
   assign valid_o       = valid_q;
   assign error_o       = error_q;

endmodule

// File: tb/tb_route_compute_unit.sv
module tb_route_compute_unit;
   import route_compute_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  x_cur = '0;
   logic [1:0]  y_cur = '0;
   logic [63:0] flit_in = '0;
   logic [1:0]  type_in = '0;
   logic [1:0]  vc_in = '0;
   logic        mode_in = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_in = 1'b1;

   logic        ready_s, valid_s, error_s;
   logic [63:0] flit_s;
   logic [1:0]  type_s, vc_s;
   logic [4:0]  port_s;
   logic        ready_n, valid_n, error_n;
   logic [63:0] flit_n;
   logic [1:0]  type_n, vc_n;
   logic [4:0]  port_n;

   always #5 clk = ~clk;

   route_compute_unit dut (
      .clk_i(clk), .rst_ni(rst_n), .x_cur_i(x_cur), .y_cur_i(y_cur),
      .flit_i(flit_in), .flit_type_i(type_in), .vc_id_i(vc_in), .routing_mode_i(mode_in),
      .valid_i(valid_in), .ready_o(ready_s), .flit_o(flit_s), .flit_type_o(type_s),
      .vc_id_o(vc_s), .port_onehot_o(port_s), .valid_o(valid_s), .ready_i(ready_in),
      .error_o(error_s)
   );

   // Same traffic, Y ids increasing northwards
   route_compute_unit #(.NodeIdIncreaseYAxis(DIRECTION_NORTH)) dut_n (
      .clk_i(clk), .rst_ni(rst_n), .x_cur_i(x_cur), .y_cur_i(y_cur),
      .flit_i(flit_in), .flit_type_i(type_in), .vc_id_i(vc_in), .routing_mode_i(mode_in),
      .valid_i(valid_in), .ready_o(ready_n), .flit_o(flit_n), .flit_type_o(type_n),
      .vc_id_o(vc_n), .port_onehot_o(port_n), .valid_o(valid_n), .ready_i(ready_in),
      .error_o(error_n)
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [63:0] flit;
      logic [1:0]  ftype;
      logic [1:0]  vc;
      logic [4:0]  port_s;
      logic [4:0]  port_n;
   } item_t;

   item_t      q[$];
   logic [4:0] mroute_s[4];
   logic [4:0] mroute_n[4];
   bit         mactive[4];
   bit         merror;

   function automatic logic [4:0] dir_bit(int unsigned d);
      logic [4:0] r;
      r = '0;
      r[d] = 1'b1;
      return r;
   endfunction

   function automatic logic [4:0] model_route(int xc, int yc, int xd, int yd, bit yx,
                                              bit y_inc_north);
      int unsigned ew, ns;
      ew = (xd > xc) ? DIRECTION_EAST : DIRECTION_WEST;
      if (yd > yc) ns = y_inc_north ? DIRECTION_NORTH : DIRECTION_SOUTH;
      else         ns = y_inc_north ? DIRECTION_SOUTH : DIRECTION_NORTH;
      if (xd == xc && yd == yc) return dir_bit(DIRECTION_LOCAL);
      if (!yx) return (xd != xc) ? dir_bit(ew) : dir_bit(ns);
      return (yd != yc) ? dir_bit(ns) : dir_bit(ew);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit    acc;
      int    v;
      item_t it;
      if (!rst_n) begin
         q.delete();
         for (int i = 0; i < 4; i++) mactive[i] = 1'b0;
         merror = 1'b0;
      end else begin
         acc = valid_in && (q.size() == 0 || ready_in);
         if (q.size() > 0 && ready_in) void'(q.pop_front());
         if (acc) begin
            v        = int'(vc_in);
            it.flit  = flit_in;
            it.ftype = type_in;
            it.vc    = vc_in;
            if (type_in == FLIT_TYPE_HEAD || type_in == FLIT_TYPE_HEADTAIL) begin
               it.port_s = model_route(x_cur, y_cur, flit_in[1:0], flit_in[3:2], mode_in, 0);
               it.port_n = model_route(x_cur, y_cur, flit_in[1:0], flit_in[3:2], mode_in, 1);
               if (type_in == FLIT_TYPE_HEAD) begin
                  if (mactive[v]) merror = 1'b1;
                  mactive[v]  = 1'b1;
                  mroute_s[v] = it.port_s;
                  mroute_n[v] = it.port_n;
               end
               q.push_back(it);
            end else if (!mactive[v]) begin
               merror = 1'b1;
            end else begin
               it.port_s = mroute_s[v];
               it.port_n = mroute_n[v];
               q.push_back(it);
               if (type_in == FLIT_TYPE_TAIL) mactive[v] = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         check("valid_o", valid_s, q.size() != 0);
         check("valid_o_n", valid_n, q.size() != 0);
         check("ready_o", ready_s, (q.size() == 0) || ready_in);
         check("ready_o_n", ready_n, (q.size() == 0) || ready_in);
         check("error_o", error_s, merror);
         check("error_o_n", error_n, merror);
         if (q.size() != 0) begin
            check("flit_o", flit_s, q[0].flit);
            check("flit_type_o", type_s, q[0].ftype);
            check("vc_id_o", vc_s, q[0].vc);
            check("port_onehot_o", port_s, q[0].port_s);
            check("port_onehot_o_n", port_n, q[0].port_n);
            check("flit_o_n", flit_n, q[0].flit);
         end
      end
   end

   // ---------------- stimulus ----------------
   bit bp_rand = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_rand) ready_in = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(int n);
      valid_in = 1'b0;
      repeat (n) tick();
   endtask

   // Holds the flit on the inputs until it is taken; returns 1 ns after the accepting edge
   task automatic send(logic [1:0] t, int v, bit m, logic [63:0] payload);
      bit ok;
      int n;
      type_in  = t;
      vc_in    = 2'(v);
      mode_in  = m;
      flit_in  = payload;
      valid_in = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = ready_s;
         tick();
         n++;
      end
      check("send_accepted", ok, 1'b1);
   endtask

   function automatic logic [63:0] mk_head(int xd, int yd);
      logic [63:0] p;
      p = {$urandom, $urandom};
      p[1:0] = 2'(xd);
      p[3:2] = 2'(yd);
      return p;
   endfunction

   bit          open_vc[4];
   logic [63:0] held;
   logic [63:0] pay;

   initial begin
      #12;
      check("rst_valid", valid_s, 1'b0);
      check("rst_flit", flit_s, 64'h0);
      check("rst_port", port_s, 5'b0);
      check("rst_error", error_s, 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      tick();

      // XY EAST packet on vc0
      x_cur = 2'd1;
      y_cur = 2'd1;
      pay = mk_head(3, 0);
      send(FLIT_TYPE_HEAD, 0, ROUTING_MODE_XY, pay);
      check("t1_latency", flit_s, pay);
      check("t1_head_east", port_s, 5'b00100);
      send(FLIT_TYPE_BODY, 0, ROUTING_MODE_XY, {$urandom, $urandom});
      check("t1_body_east", port_s, 5'b00100);
      send(FLIT_TYPE_TAIL, 0, ROUTING_MODE_XY, {$urandom, $urandom});
      check("t1_tail_east", port_s, 5'b00100);
      idle(1);
      check("t1_vc0_closed", dut.active_q[0], 1'b0);

      // YX: Y resolved first
      send(FLIT_TYPE_HEADTAIL, 1, ROUTING_MODE_YX, mk_head(3, 0));
      check("t2_yx_north", port_s, 5'b00010);
      check("t2_yx_north_inc", port_n, 5'b01000);

      // Interleaved packets on vc1 (LOCAL) and vc2 (WEST)
      send(FLIT_TYPE_HEAD, 1, ROUTING_MODE_XY, mk_head(1, 1));
      check("t3_local", port_s, 5'b00001);
      send(FLIT_TYPE_HEAD, 2, ROUTING_MODE_XY, mk_head(0, 1));
      check("t3_west", port_s, 5'b10000);
      for (int i = 0; i < 4; i++) begin
         send(FLIT_TYPE_BODY, (i % 2 == 1) ? 2 : 1, ROUTING_MODE_YX, {$urandom, $urandom});
         check("t3_body_route", port_s, (i % 2 == 1) ? 5'b10000 : 5'b00001);
      end
      send(FLIT_TYPE_TAIL, 1, ROUTING_MODE_XY, {$urandom, $urandom});
      send(FLIT_TYPE_TAIL, 2, ROUTING_MODE_XY, {$urandom, $urandom});

      // Backpressure: output held while ready_i low
      send(FLIT_TYPE_HEAD, 0, ROUTING_MODE_XY, mk_head(2, 3));
      held = flit_s;
      ready_in = 1'b0;
      type_in  = FLIT_TYPE_BODY;
      flit_in  = {$urandom, $urandom};
      repeat (3) begin
         @(negedge clk);
         check("t4_ready_low", ready_s, 1'b0);
         check("t4_flit_held", flit_s, held);
         @(posedge clk);
         #1;
      end
      ready_in = 1'b1;
      send(FLIT_TYPE_BODY, 0, ROUTING_MODE_XY, flit_in);
      send(FLIT_TYPE_TAIL, 0, ROUTING_MODE_XY, {$urandom, $urandom});
      // TAIL then HEAD on the same VC back-to-back is legal
      send(FLIT_TYPE_HEAD, 0, ROUTING_MODE_YX, mk_head(1, 2));
      send(FLIT_TYPE_TAIL, 0, ROUTING_MODE_YX, {$urandom, $urandom});
      idle(1);
      check("t4_no_error", error_s, 1'b0);

      // BODY on inactive vc3 is dropped and flagged
      send(FLIT_TYPE_BODY, 3, ROUTING_MODE_XY, {$urandom, $urandom});
      check("t5_drop_valid", valid_s, 1'b0);
      check("t5_error_set", error_s, 1'b1);
      send(FLIT_TYPE_HEAD, 3, ROUTING_MODE_XY, mk_head(0, 0));
      send(FLIT_TYPE_TAIL, 3, ROUTING_MODE_XY, {$urandom, $urandom});
      idle(1);
      check("t5_error_sticky", error_s, 1'b1);

      // Random traffic with random backpressure
      x_cur = 2'($urandom_range(0, 3));
      y_cur = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) open_vc[i] = dut.active_q[i];
      bp_rand = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         int v;
         logic [1:0] t;
         v = $urandom_range(0, 3);
         if (open_vc[v]) begin
            t = ($urandom_range(0, 3) == 0) ? FLIT_TYPE_TAIL : FLIT_TYPE_BODY;
            if ($urandom_range(0, 49) == 0) t = FLIT_TYPE_HEAD;
         end else begin
            t = ($urandom_range(0, 2) == 0) ? FLIT_TYPE_HEADTAIL : FLIT_TYPE_HEAD;
            if ($urandom_range(0, 49) == 0) t = FLIT_TYPE_BODY;
         end
         if (t == FLIT_TYPE_HEAD) open_vc[v] = 1'b1;
         if (t == FLIT_TYPE_TAIL) open_vc[v] = 1'b0;
         send(t, v, 1'($urandom_range(0, 1)), {$urandom, $urandom});
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      bp_rand  = 1'b0;
      ready_in = 1'b1;
      idle(3);

      // Reset mid-packet on vc0
      x_cur = 2'd1;
      y_cur = 2'd1;
      send(FLIT_TYPE_HEAD, 0, ROUTING_MODE_XY, mk_head(3, 3));
      send(FLIT_TYPE_BODY, 0, ROUTING_MODE_XY, {$urandom, $urandom});
      valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t7_rst_valid", valid_s, 1'b0);
      check("t7_rst_flit", flit_s, 64'h0);
      check("t7_rst_type", type_s, 2'b0);
      check("t7_rst_vc", vc_s, 2'b0);
      check("t7_rst_port", port_s, 5'b0);
      check("t7_rst_error", error_s, 1'b0);
      check("t7_rst_active", dut.active_q, 4'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send(FLIT_TYPE_BODY, 0, ROUTING_MODE_XY, {$urandom, $urandom});
      check("t7_post_rst_drop", valid_s, 1'b0);
      check("t7_post_rst_error", error_s, 1'b1);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/route_compute_unit.md
# route_compute_unit

Per-input-port, VC-aware route computation stage of the virtual-channel router. Sits between an input-port buffer and VC/switch allocation. Head flits get a dimension-order route (XY or YX, selectable per packet) computed from destination coordinates in the flit. The route is held per VC until the tail flit. Each flit is forwarded through one registered valid/ready stage tagged with a one-hot output-port vector.

## Interface
Parameters:
- `FlitWidth`, 64: flit payload width.
- `DimensionXWidth`, 2: X coordinate width.
- `DimensionYWidth`, 2: Y coordinate width.
- `DstXLsb`, 0: LSB of destination X field inside a head flit.
- `DstYLsb`, 2: LSB of destination Y field inside a head flit.
- `NumberOfVirtualChannels`, 4: VCs per input port; `VcIdWidth` = max(1, clog2 of it), derived.
- `NumberOfPorts`, 5: output ports; bit order is the shared port-direction index constants.
- `NodeIdIncreaseXAxis`, `DIRECTION_EAST`: direction of increasing X (EAST/WEST).
- `NodeIdIncreaseYAxis`, `DIRECTION_SOUTH`: direction of increasing Y (NORTH/SOUTH).

Ports:
- `clk_i` in 1: clock; the block has one clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `x_cur_i` in DimensionXWidth: this node's X coordinate, quasi-static.
- `y_cur_i` in DimensionYWidth: this node's Y coordinate, quasi-static.
- `flit_i` in FlitWidth: incoming flit.
- `flit_type_i` in 2: BODY=00, HEAD=01, TAIL=10, HEADTAIL=11.
- `vc_id_i` in VcIdWidth: VC of the incoming flit.
- `routing_mode_i` in 1: 0=XY, 1=YX; sampled only on accepted HEAD/HEADTAIL.
- `valid_i` in 1 / `ready_o` out 1: input handshake.
- `flit_o` out FlitWidth, `flit_type_o` out 2, `vc_id_o` out VcIdWidth: registered flit.
- `port_onehot_o` out NumberOfPorts: route of `flit_o`.
- `valid_o` out 1 / `ready_i` in 1: output handshake.
- `error_o` out 1: sticky protocol-error flag.

## Operation
- Accept condition: `valid_i & ready_o`. `ready_o = ~valid_o | ready_i` (combinational; no bubble under continuous ready).
- Routing follows dimension order and honours the NodeIdIncrease parameters.
  - XY: resolve X first (E/W), then Y (N/S).
  - YX: resolve Y first, then X.
  - dst == cur gives LOCAL.
  - Exactly one bit is set.
- HEAD accepted:
  - compute the route;
  - set `route_q[vc]` and `active_q[vc]` = 1;
  - forward the flit with the route.
- HEADTAIL accepted: compute the route and forward; per-VC state is unchanged.
- BODY accepted on an active VC: forward with `route_q[vc]`.
- TAIL accepted on an active VC: forward with `route_q[vc]`; clear `active_q[vc]` at the same edge.
- BODY/TAIL on an inactive VC: consume the flit, do not forward it (`valid_o` not set by this flit), set `error_o`.
- HEAD on an already active VC: overwrite the route, forward the flit, set `error_o`.
- `error_o` clears only on reset.

## Timing
- Reset (async assert, sync release): `valid_o`=0, `flit_o`=0, `flit_type_o`=0, `vc_id_o`=0, `port_onehot_o`=0, `error_o`=0, all `active_q`=0.
- Latency: a flit accepted at edge N is on the outputs after edge N; throughput is 1 flit/cycle.
- Output is held stable while `valid_o & ~ready_i`.
- Output register loads on accept.
- `valid_o` clears on `ready_i` with no accept, or when the accepted flit is a dropped errored flit.
- TAIL then HEAD on the same VC in consecutive cycles is legal with no error.
- Reset mid-packet discards all routes. A later BODY on that VC is an error.

## Structure
- Shared header holds:
  - flit-type encodings (`FLIT_TYPE_*`);
  - routing-mode encodings (`ROUTING_MODE_XY`/`_YX`);
  - the existing port-direction index and `DIRECTION_*` constants.
- One combinational sub-module, `route_select_dor`: coordinates + mode + NodeIdIncrease params → one-hot port.
- The top level holds the handshake register and per-VC route/active arrays.

## Test plan
- XY, cur=(1,1), dst=(3,0), HEAD vc0 then BODY, TAIL → three flits out, each with EAST one-hot, 1-cycle latency; `active_q[0]`=0 afterwards.
- YX, same coordinates → NORTH (Y increases southwards); the same pair with NodeIdIncreaseYAxis=NORTH → SOUTH.
- Interleaved HEAD vc1 dst=(1,1) (LOCAL) and HEAD vc2 dst=(0,1) (WEST), then bodies alternating vc1/vc2 → each body carries its own VC's route.
- `ready_i` low 3 cycles with `valid_i` high → `ready_o` low, outputs stable, no flit lost or duplicated; a random-backpressure run of 1000 flits matches the scoreboard.
- BODY on inactive vc3 → no output flit, `error_o`=1 and stays 1 through later legal traffic until `rst_ni` pulses.
- `rst_ni` asserted mid-packet on vc0 → outputs zero immediately (async); the post-reset BODY vc0 is dropped with error.
